// File: rtl/modular_inverse.sv
// ----------------------------------------------------------------------------
// modular_inverse
//
// Finds the multiplicative inverse of a 3-bit operand X modulo a 3-bit
// modulus Z by iterative search. The operand is first reduced below the
// modulus by repeated subtraction. The block then walks k = 1, 2, ... while
// keeping acc = k*x mod z. The first k with acc == 1 is the inverse. If k
// reaches z-1 without a hit, no inverse exists.
//
// Ports
//   clk    : rising-edge clock
//   reset  : synchronous, active-high reset
//   start  : request pulse, accepted only while idle
//   X      : operand whose inverse is wanted (captured on accept)
//   Z      : modulus (captured on accept)
//   Y      : inverse of X mod Z when valid=1, otherwise 0
//   valid  : 1 when an inverse exists and Y holds it
//   done   : one-cycle completion pulse (state DONE)
//   busy   : high while the search is in progress
//   state  : debug state code (IDLE=0, CHECK=1, REDUCE=2, STEP=3, DONE=4)
// ----------------------------------------------------------------------------
module modular_inverse (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] X,
    input  logic [2:0] Z,
    output logic [2:0] Y,
    output logic       valid,
    output logic       done,
    output logic       busy,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        CHECK  = 4'd1,
        REDUCE = 4'd2,
        STEP   = 4'd3,
        DONE   = 4'd4
    } state_t;

    state_t     cur_state, nxt_state;

    logic [2:0] xr, xr_nxt;
    logic [2:0] zr, zr_nxt;
    logic [2:0] k, k_nxt;
    logic [3:0] acc, acc_nxt;
    logic [2:0] y_reg, y_nxt;
    logic       valid_reg, valid_nxt;

    // acc and xr are both below zr during STEP, so their sum is at most 12
    // and a single conditional subtraction of zr brings it back into range.
    logic [3:0] acc_sum;
    logic [3:0] acc_mod;

    // Register every piece of state on the rising edge. Reset forces the
    // whole block back to a clean idle condition, which also aborts any
    // search in flight without producing a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= IDLE;
            xr        <= 3'd0;
            zr        <= 3'd0;
            k         <= 3'd0;
            acc       <= 4'd0;
            y_reg     <= 3'd0;
            valid_reg <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            xr        <= xr_nxt;
            zr        <= zr_nxt;
            k         <= k_nxt;
            acc       <= acc_nxt;
            y_reg     <= y_nxt;
            valid_reg <= valid_nxt;
        end
    end

    // Next-state and datapath updates. Every register holds by default, so
    // captures and results only change where a state explicitly says so.
    always_comb begin
        nxt_state = cur_state;
        xr_nxt    = xr;
        zr_nxt    = zr;
        k_nxt     = k;
        acc_nxt   = acc;
        y_nxt     = y_reg;
        valid_nxt = valid_reg;

        acc_sum = acc + {1'b0, xr};
        acc_mod = (acc_sum >= {1'b0, zr}) ? (acc_sum - {1'b0, zr}) : acc_sum;

        case (cur_state)
            IDLE: begin
                if (start) begin
                    xr_nxt    = X;
                    zr_nxt    = Z;
                    y_nxt     = 3'd0;
                    valid_nxt = 1'b0;
                    nxt_state = CHECK;
                end
            end

            // Moduli 0 and 1 have no meaningful inverse.
            CHECK: begin
                if (zr < 3'd2) begin
                    y_nxt     = 3'd0;
                    valid_nxt = 1'b0;
                    nxt_state = DONE;
                end else begin
                    nxt_state = REDUCE;
                end
            end

            // One subtraction per cycle until xr < zr. An operand that is a
            // multiple of the modulus reduces to 0 and has no inverse.
            REDUCE: begin
                if (xr >= zr) begin
                    xr_nxt = xr - zr;
                end else if (xr == 3'd0) begin
                    y_nxt     = 3'd0;
                    valid_nxt = 1'b0;
                    nxt_state = DONE;
                end else begin
                    acc_nxt   = {1'b0, xr};
                    k_nxt     = 3'd1;
                    nxt_state = STEP;
                end
            end

            // acc tracks k*xr mod zr. zr is at least 2 here, so zr-1 is safe.
            STEP: begin
                if (acc == 4'd1) begin
                    y_nxt     = k;
                    valid_nxt = 1'b1;
                    nxt_state = DONE;
                end else if (k == (zr - 3'd1)) begin
                    y_nxt     = 3'd0;
                    valid_nxt = 1'b0;
                    nxt_state = DONE;
                end else begin
                    acc_nxt = acc_mod;
                    k_nxt   = k + 3'd1;
                end
            end

            DONE: begin
                nxt_state = IDLE;
            end

            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    // Status outputs decode directly from the current state.
    always_comb begin
        done  = (cur_state == DONE);
        busy  = (cur_state == CHECK) || (cur_state == REDUCE) || (cur_state == STEP);
        state = cur_state;
        Y     = y_reg;
        valid = valid_reg;
    end

endmodule

// File: tb/tb_modular_inverse.sv
// ----------------------------------------------------------------------------
// tb_modular_inverse
//
// Scoreboard bench for modular_inverse. Stimulus pushes the expected result
// (Y, valid, latency) into a queue when it issues a start. A monitor pops
// and compares on every done pulse. It also checks busy during the search,
// one-cycle done, result hold after done, and X*Y mod Z == 1 when valid.
// ----------------------------------------------------------------------------
module tb_modular_inverse;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] X;
    logic [2:0] Z;
    logic [2:0] Y;
    logic       valid;
    logic       done;
    logic       busy;
    logic [3:0] state;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        int x;
        int z;
        int y;
        int v;
        int lat;
    } exp_t;

    exp_t sb[$];

    modular_inverse dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .X     (X),
        .Z     (Z),
        .Y     (Y),
        .valid (valid),
        .done  (done),
        .busy  (busy),
        .state (state)
    );

    // 10 ns clock period
    always #5 clk = ~clk;

    // Hard time limit so a stuck design can never hang the run
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference: brute-force inverse search plus the latency of the
    // reduce-then-step algorithm (r = number of reduce subtractions)
    function automatic void refModel(input int x, input int z,
                                     output int y, output int v, output int lat);
        int r;
        int xm;
        y = 0;
        v = 0;
        if (z < 2) begin
            lat = 2;
        end else begin
            r  = x / z;
            xm = x % z;
            if (xm == 0) begin
                lat = 3 + r;
            end else begin
                for (int yy = 1; yy < z; yy++) begin
                    if (v == 0 && ((xm * yy) % z) == 1) begin
                        y = yy;
                        v = 1;
                    end
                end
                lat = (v == 1) ? (3 + r + y) : (3 + r + z - 1);
            end
        end
    endfunction

    // Wait (bounded) until the DUT is idle, sampled on the falling edge
    task automatic waitIdle();
        int n = 0;
        while (state !== 4'd0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) checkOutput("waitIdleTimeout", 32'(state), 32'd0);
    endtask

    // Issue one start pulse and record what the monitor should see for it
    task automatic applyStimulus(input int x, input int z, input int y,
                                 input int v, input int lat);
        exp_t e;
        waitIdle();
        e.x   = x;
        e.z   = z;
        e.y   = y;
        e.v   = v;
        e.lat = lat;
        sb.push_back(e);
        X     = 3'(x);
        Z     = 3'(z);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for every outstanding expectation to be consumed
    task automatic waitDrain();
        int n = 0;
        while (sb.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            checkOutput("drainTimeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: samples 1 ns after each rising edge. cnt is the cycle number
    // of the current operation with the accepting edge counted as cycle 1.
    int         cnt = 0;
    logic [3:0] prevState = 4'd0;
    logic       prevDone  = 1'b0;
    logic       holdPending = 1'b0;
    int         holdY = 0;
    int         holdV = 0;

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (reset === 1'b1) begin
            cnt         = 0;
            holdPending = 1'b0;
        end else begin
            if (holdPending) begin
                checkOutput("holdY", 32'(Y), 32'(holdY));
                checkOutput("holdValid", 32'(valid), 32'(holdV));
                holdPending = 1'b0;
            end
            if (state === 4'd1 && prevState === 4'd0) cnt = 1;
            else if (cnt != 0) cnt++;
            if (cnt > 0 && done !== 1'b1) checkOutput("busyDuringOp", 32'(busy), 32'd1);
            if (done === 1'b1) begin
                checkOutput("doneOneCycle", 32'(prevDone), 32'd0);
                checkOutput("busyAtDone", 32'(busy), 32'd0);
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpectedDone: got done with Y=%0d valid=%0d, expected none",
                             Y, valid);
                end else begin
                    e = sb.pop_front();
                    checkOutput($sformatf("Y(X=%0d,Z=%0d)", e.x, e.z), 32'(Y), 32'(e.y));
                    checkOutput($sformatf("valid(X=%0d,Z=%0d)", e.x, e.z), 32'(valid), 32'(e.v));
                    checkOutput($sformatf("latency(X=%0d,Z=%0d)", e.x, e.z), 32'(cnt), 32'(e.lat));
                    if (valid === 1'b1 && e.z >= 2)
                        checkOutput($sformatf("inverse(X=%0d,Z=%0d)", e.x, e.z),
                                    32'((e.x * int'(Y)) % e.z), 32'd1);
                    holdY       = e.y;
                    holdV       = e.v;
                    holdPending = 1'b1;
                end
                cnt = 0;
            end
        end
        prevState = state;
        prevDone  = done;
    end

    initial begin
        int ey;
        int ev;
        int el;

        reset = 1'b1;
        start = 1'b0;
        X     = 3'd0;
        Z     = 3'd0;
        repeat (2) @(negedge clk);

        $display("[TB] checking reset state");
        checkOutput("resetState", 32'(state), 32'd0);
        checkOutput("resetY", 32'(Y), 32'd0);
        checkOutput("resetValid", 32'(valid), 32'd0);
        checkOutput("resetDone", 32'(done), 32'd0);
        checkOutput("resetBusy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] directed vectors");
        applyStimulus(3, 7, 5, 1, 8);
        applyStimulus(7, 2, 1, 1, 7);
        applyStimulus(2, 4, 0, 0, 6);
        applyStimulus(7, 7, 0, 0, 4);
        applyStimulus(6, 3, 0, 0, 5);
        applyStimulus(5, 1, 0, 0, 2);
        applyStimulus(5, 0, 0, 0, 2);
        applyStimulus(0, 5, 0, 0, 3);
        waitDrain();

        $display("[TB] start while busy is ignored");
        applyStimulus(3, 7, 5, 1, 8);
        repeat (3) @(negedge clk);
        X     = 3'd1;
        Z     = 3'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDrain();

        $display("[TB] reset aborts an operation");
        waitIdle();
        X     = 3'd3;
        Z     = 3'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("abortInStep", 32'(state), 32'd3);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abortState", 32'(state), 32'd0);
        checkOutput("abortY", 32'(Y), 32'd0);
        checkOutput("abortValid", 32'(valid), 32'd0);
        checkOutput("abortDone", 32'(done), 32'd0);
        checkOutput("abortBusy", 32'(busy), 32'd0);
        reset = 1'b0;
        applyStimulus(1, 3, 1, 1, 4);
        waitDrain();

        $display("[TB] reset wins over start");
        reset = 1'b1;
        start = 1'b1;
        X     = 3'd1;
        Z     = 3'd3;
        @(negedge clk);
        checkOutput("resetStartState", 32'(state), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkOutput("resetStartStillIdle", 32'(state), 32'd0);

        $display("[TB] start held high runs back-to-back operations");
        waitIdle();
        begin
            exp_t e;
            e.x   = 1;
            e.z   = 3;
            e.y   = 1;
            e.v   = 1;
            e.lat = 4;
            sb.push_back(e);
            sb.push_back(e);
        end
        X     = 3'd1;
        Z     = 3'd3;
        start = 1'b1;
        repeat (8) @(negedge clk);
        start = 1'b0;
        waitDrain();

        $display("[TB] sweep X=1..7, Z=2..7");
        for (int x = 1; x <= 7; x++) begin
            for (int z = 2; z <= 7; z++) begin
                refModel(x, z, ey, ev, el);
                applyStimulus(x, z, ey, ev, el);
            end
        end
        waitDrain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/modular_inverse.md
MODULAR_INVERSE -- requirements
Module: modular_inverse

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 clk  input  1  rising-edge clock; all state changes occur on this edge.
REQ-003 reset  input  1  synchronous, active-high; sampled only on the rising edge of clk.
REQ-004 start  input  1  request pulse; accepted only in state IDLE.
REQ-005 X  input  3  operand whose inverse is wanted; captured when start is accepted.
REQ-006 Z  input  3  modulus; captured when start is accepted.
REQ-007 Y  output  3  result: the inverse of X mod Z when valid=1, else 0.
REQ-008 valid  output  1  1 = inverse exists and Y holds it; 0 = no inverse or no result yet.
REQ-009 done  output  1  asserted for exactly one cycle, while in state DONE.
REQ-010 busy  output  1  1 while in CHECK, REDUCE or STEP.
REQ-011 state  output  4  debug state code: IDLE=0, CHECK=1, REDUCE=2, STEP=3, DONE=4.

Function
REQ-012 In IDLE with start=1, the block SHALL capture X into xr (3-bit) and Z into zr (3-bit), clear Y and valid, and go to CHECK.
REQ-013 In IDLE with start=0, or in any state other than IDLE, the block SHALL ignore start and hold X/Z captures unchanged.
REQ-014 In CHECK, if zr<2 the block SHALL go to DONE with valid=0 and Y=0; otherwise it SHALL go to REDUCE.
REQ-015 In REDUCE, if xr>=zr then xr SHALL become xr-zr and the state SHALL stay REDUCE; this takes one subtraction per cycle, count r.
REQ-016 In REDUCE, if xr<zr and xr=0, the block SHALL go to DONE with valid=0 and Y=0.
REQ-017 In REDUCE, if xr<zr and xr!=0, the block SHALL set acc=xr and k=1 and go to STEP.
REQ-018 acc SHALL be at least 4 bits wide so that acc+xr (at most 12) does not overflow; k SHALL be 3 bits.
REQ-019 In STEP, if acc=1, the block SHALL set Y=k and valid=1 and go to DONE.
REQ-020 In STEP, if acc!=1 and k=zr-1, the block SHALL set Y=0 and valid=0 and go to DONE.
REQ-021 In STEP, if acc!=1 and k!=zr-1, the block SHALL set acc=(acc+xr) mod zr and k=k+1, where the mod is a single conditional subtraction of zr.
REQ-022 In DONE, the block SHALL assert done=1 and then return to IDLE on the next edge.
REQ-023 Y and valid SHALL hold their values from DONE until the next accepted start.
REQ-024 Latency SHALL be counted from the start-accepting edge to the edge that enters DONE:
  - zr<2: 2 cycles.
  - xr reduces to 0: 3+r cycles.
  - inverse found: 3+r+Y cycles.
  - no inverse: 3+r+(zr-1) cycles.
REQ-025 A start held high continuously SHALL cause one new operation per return to IDLE; a start that arrives while busy SHALL NOT be queued.

Reset
REQ-026 When reset=1 at an edge, the block SHALL force the following, regardless of state: state=IDLE (0), Y=0, valid=0, done=0, busy=0, xr=0, zr=0, acc=0, k=0.
REQ-027 A reset during CHECK, REDUCE, STEP or DONE SHALL abort the operation without a done pulse; the first start after reset is released SHALL be accepted normally.
REQ-028 If reset and start are both 1 at the same edge, reset SHALL win and start SHALL be ignored.

Verification
REQ-029 X=3, Z=7, start pulse -> done 8 cycles after the start edge, Y=5, valid=1; busy=1 for cycles 1-7.
REQ-030 X=7, Z=2 -> r=3, done at cycle 7, Y=1, valid=1.
REQ-031 X=2, Z=4 -> done at cycle 6, Y=0, valid=0.
REQ-032 The following cases SHALL each give Y=0, valid=0:
  - X=7, Z=7 -> done at cycle 4.
  - X=6, Z=3 -> done at cycle 5.
  - X=5, Z=1 -> done at cycle 2.
  - X=5, Z=0 -> done at cycle 2.
REQ-033 X=3, Z=7 with reset=1 asserted at cycle 4 -> state=0 and all outputs 0 on the next cycle, and no done pulse; a following start with X=1, Z=3 -> done at cycle 4, Y=1, valid=1.
REQ-034 A start pulse while busy SHALL be ignored, with the original result unchanged; the bench SHALL check the whole sweep X=1..7, Z=2..7 against a reference model, requiring X*Y mod Z=1 whenever valid=1 and no inverse to exist whenever valid=0.
